// File: rtl/bit_ser_pkg.sv
// Shared definitions for the bit serializer: state encodings, default word
// width and the bit-counter width helper.
package bit_ser_pkg;

    localparam int BIT_SER_WIDTH_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } bit_ser_state_e;

    // Counter must index 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return ($clog2(width) < 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/bit_ser_hold.sv
// One-entry holding register for the bit serializer: captures a word on
// write, releases it on read. Asynchronous active-high reset.
module bit_ser_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o
);

    logic [WIDTH-1:0] data_q;
    logic             full_q;

    // Capture data on write; full flag set on write, cleared on read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            if (wr_i) begin
                data_q <= wr_data_i;
            end
            if (wr_i) begin
                full_q <= 1'b1;
            end else if (rd_i) begin
                full_q <= 1'b0;
            end
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-entry hold buffer so words can
// stream gap-free. Bit order is MSB first by default; defining
// BIT_SER_LSB_FIRST_EN switches to LSB first (handshake and timing unchanged).
//
//   state    | meaning
//   ST_IDLE  | shift register empty, line idles at 0
//   ST_SHIFT | shift register emitting bit cnt_q of the current word
module bit_serializer
    import bit_ser_pkg::*;
#(
    parameter int WIDTH = BIT_SER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    bit_ser_state_e   state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             accept;
    logic             last_bit;
    logic             hold_wr;
    logic             hold_rd;

    assign load_ready = !hold_full;
    assign accept     = load_valid && !hold_full;
    assign last_bit   = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    // A word arriving on the last bit with the hold empty bypasses the hold.
    assign hold_wr    = accept && (state_q == ST_SHIFT) && (cnt_q != CNT_LAST);
    assign hold_rd    = last_bit && hold_full;

    bit_ser_hold #(.WIDTH(WIDTH)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .wr_i     (hold_wr),
        .wr_data_i(load_data),
        .rd_i     (hold_rd),
        .data_o   (hold_data),
        .full_o   (hold_full)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave SHIFT only when the last bit has no successor.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit && !hold_full && !accept) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Shift register and bit counter next values.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                shift_d = load_data;
                cnt_d   = '0;
            end
        end else if (last_bit) begin
            cnt_d = '0;
            if (hold_full) begin
                shift_d = hold_data;
            end else if (accept) begin
                shift_d = load_data;
            end
        end else begin
`ifdef BIT_SER_LSB_FIRST_EN
            shift_d = shift_q >> 1;
`else
            shift_d = shift_q << 1;
`endif
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Shift register and bit counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decoded from registered state; line forced to 0 when not valid.
    always_comb begin
        ser_valid = (state_q == ST_SHIFT);
        ser_last  = ser_valid && (cnt_q == CNT_LAST);
`ifdef BIT_SER_LSB_FIRST_EN
        ser_out   = ser_valid && shift_q[0];
`else
        ser_out   = ser_valid && shift_q[WIDTH-1];
`endif
        busy      = ser_valid || hold_full;
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: a WIDTH=5 instance for handshake and
// streaming cases, and a WIDTH=8 instance for the 8'hA5 case. Expected bit
// order follows BIT_SER_LSB_FIRST_EN.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ld5;
    logic       lv5, lr5, so5, sv5, sl5, bz5;
    logic [7:0] ld8;
    logic       lv8, lr8, so8, sv8, sl8, bz8;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .load_data(ld5), .load_valid(lv5), .load_ready(lr5),
        .ser_out(so5), .ser_valid(sv5), .ser_last(sl5), .busy(bz5)
    );

    bit_serializer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .load_data(ld8), .load_valid(lv8), .load_ready(lr8),
        .ser_out(so8), .ser_valid(sv8), .ser_last(sl8), .busy(bz8)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Bit i of word w as it should appear on the line.
    function automatic logic exp_bit(input logic [31:0] w, input int i, input int width);
`ifdef BIT_SER_LSB_FIRST_EN
        return w[i];
`else
        return w[width-1-i];
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit5(input string tag, input logic [31:0] w, input int i);
        chk({tag, "_out"}, {31'd0, so5}, {31'd0, exp_bit(w, i, 5)});
        chk({tag, "_vld"}, {31'd0, sv5}, 32'd1);
        chk({tag, "_last"}, {31'd0, sl5}, {31'd0, (i == 4)});
    endtask

    task automatic chk_idle5(input string tag);
        chk({tag, "_vld"}, {31'd0, sv5}, 32'd0);
        chk({tag, "_out"}, {31'd0, so5}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bz5}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, lr5}, 32'd1);
    endtask

    localparam logic [31:0] W_A = 32'b10110;
    localparam logic [31:0] W_B = 32'b01101;
    localparam logic [31:0] W_C = 32'b11001;
    localparam logic [31:0] W_8 = 32'hA5;

    initial begin
        rst = 1'b1;
        ld5 = '0; lv5 = 1'b0; ld8 = '0; lv8 = 1'b0;
        #2;
        chk_idle5("rst_async");
        step();
        step();
        rst = 1'b0;
        step();
        chk_idle5("rst_rel");
        chk("rst_last", {31'd0, sl5}, 32'd0);
        chk("rst8_rdy", {31'd0, lr8}, 32'd1);

        // single word from IDLE
        lv5 = 1'b1; ld5 = W_A[4:0];
        step();
        lv5 = 1'b0; ld5 = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            chk_bit5("single", W_A, i);
            step();
        end
        chk_idle5("single_end");

        // WIDTH=8, 8'hA5
        lv8 = 1'b1; ld8 = W_8[7:0];
        step();
        lv8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("w8_out", {31'd0, so8}, {31'd0, exp_bit(W_8, i, 8)});
            chk("w8_last", {31'd0, sl8}, {31'd0, (i == 7)});
            step();
        end
        chk("w8_end_vld", {31'd0, sv8}, 32'd0);
        chk("w8_end_busy", {31'd0, bz8}, 32'd0);

        // back-to-back through the hold buffer
        lv5 = 1'b1; ld5 = W_A[4:0];
        step();
        ld5 = W_B[4:0];
        chk_bit5("b2b_a", W_A, 0);
        chk("b2b_rdy_pre", {31'd0, lr5}, 32'd1);
        step();
        lv5 = 1'b0; ld5 = 5'b11111;
        for (int i = 1; i < 5; i++) begin
            chk_bit5("b2b_a", W_A, i);
            chk("b2b_rdy_lo", {31'd0, lr5}, 32'd0);
            chk("b2b_busy", {31'd0, bz5}, 32'd1);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            chk_bit5("b2b_b", W_B, i);
            chk("b2b_rdy_hi", {31'd0, lr5}, 32'd1);
            step();
        end
        chk_idle5("b2b_end");

        // word offered exactly on the last bit with hold empty
        lv5 = 1'b1; ld5 = W_A[4:0];
        step();
        lv5 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_bit5("direct_a", W_A, i);
            step();
        end
        chk_bit5("direct_a", W_A, 4);
        lv5 = 1'b1; ld5 = W_C[4:0];
        step();
        lv5 = 1'b0; ld5 = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            chk_bit5("direct_c", W_C, i);
            chk("direct_rdy", {31'd0, lr5}, 32'd1);
            step();
        end
        chk_idle5("direct_end");

        // valid while not ready: C waits, then is serialized once
        lv5 = 1'b1; ld5 = W_A[4:0];
        step();
        ld5 = W_B[4:0];
        step();
        ld5 = W_C[4:0];
        for (int i = 1; i < 5; i++) begin
            chk_bit5("stall_a", W_A, i);
            chk("stall_rdy_lo", {31'd0, lr5}, 32'd0);
            step();
        end
        chk_bit5("stall_b", W_B, 0);
        chk("stall_rdy_hi", {31'd0, lr5}, 32'd1);
        step();
        lv5 = 1'b0; ld5 = 5'b00000;
        for (int i = 1; i < 5; i++) begin
            chk_bit5("stall_b", W_B, i);
            chk("stall_rdy_lo2", {31'd0, lr5}, 32'd0);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            chk_bit5("stall_c", W_C, i);
            step();
        end
        chk_idle5("stall_end");
        step();
        chk_idle5("stall_once");

        // reset on the 3rd bit with a held word
        lv5 = 1'b1; ld5 = W_A[4:0];
        step();
        ld5 = W_B[4:0];
        step();
        lv5 = 1'b0;
        step();
        chk_bit5("rst_mid_a", W_A, 2);
        chk("rst_mid_busy", {31'd0, bz5}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk_idle5("rst_mid_async");
        chk("rst_mid_last", {31'd0, sl5}, 32'd0);
        #1 rst = 1'b0;
        step();
        chk_idle5("rst_mid_after");
        step();
        chk_idle5("rst_mid_lost");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
